// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle integer divider.
// States, op codes, datapath width, iteration count and op-decoding helpers.
package div_pkg;

  localparam int XLEN       = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  // Encoding matches funct3[1:0] of the M-extension divide group.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_t;

  function automatic logic op_is_signed(input op_t o);
    return (o == OP_DIV) || (o == OP_REM);
  endfunction

  function automatic logic op_is_rem(input op_t o);
    return (o == OP_REM) || (o == OP_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift remainder, trial subtract, quotient bit.
// Purely combinational; no latency, no flow control.
module div_step
  import div_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] quo_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic [W-1:0] quo_out
);

  logic [W:0]   shifted;
  logic [W-1:0] diff;
  logic         fits;

  assign shifted = {rem_in, quo_in[W-1]};
  assign fits    = shifted >= {1'b0, divisor};
  // When the subtract fits, the true difference is below the divisor, so the
  // low W bits of the modular difference are exact.
  assign diff    = shifted[W-1:0] - divisor;

  assign rem_out = fits ? diff : shifted[W-1:0];
  assign quo_out = {quo_in[W-2:0], fits};

endmodule

// File: rtl/divider.sv
// Iterative 32-bit DIV/DIVU/REM/REMU: 33-cycle latency from start to done, 1 for /0 and overflow.
// start is only sampled in IDLE; requests while busy are dropped, never queued.
module divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] out
);

  import div_pkg::*;

  state_t            state, state_nxt;
  op_t               op_q;
  logic [XLEN-1:0]   quo_q, dvs_q, rem_q, out_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              q_neg_q, r_neg_q;

  op_t               op_in;
  logic              sgn_in, a_neg, b_neg, div_zero, ovf, fast;
  logic [XLEN-1:0]   a_mag, b_mag, fast_out;
  logic [XLEN-1:0]   step_rem, step_quo, q_fin, r_fin, res;
  logic              last_iter;

  assign op_in  = op_t'(op);
  assign sgn_in = op_is_signed(op_in);
  assign a_neg  = sgn_in & in1[XLEN-1];
  assign b_neg  = sgn_in & in2[XLEN-1];
  assign a_mag  = a_neg ? -in1 : in1;
  assign b_mag  = b_neg ? -in2 : in2;

  // Divide-by-zero and signed overflow resolve without iterating.
  assign div_zero = (in2 == '0);
  assign ovf      = sgn_in && (in1 == {1'b1, {(XLEN-1){1'b0}}}) && (&in2);
  assign fast     = div_zero | ovf;

  always_comb begin
    fast_out = '0;
    if (div_zero)
      fast_out = op_is_rem(op_in) ? in1 : '1;
    else if (ovf)
      fast_out = op_is_rem(op_in) ? '0 : in1;
  end

  div_step #(.W(XLEN)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  assign q_fin     = q_neg_q ? -step_quo : step_quo;
  assign r_fin     = r_neg_q ? -step_rem : step_rem;
  assign res       = op_is_rem(op_q) ? r_fin : q_fin;
  assign last_iter = (cnt_q == CNT_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = fast ? DONE : CALC;
      CALC: if (last_iter) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= OP_DIV;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op_in;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            quo_q   <= a_mag;
            dvs_q   <= b_mag;
            rem_q   <= '0;
            cnt_q   <= CNT_W'(ITER_COUNT);
            if (fast) out_q <= fast_out;
          end
        end
        CALC: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q - CNT_W'(1);
          if (last_iter) out_q <= res;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);
  assign out  = out_q;

endmodule
